// File: rtl/sd_bd_store_pkg.sv
// Shared defines for the SD DMA descriptor store: default sizing and read-FSM encodings.
package sd_bd_store_pkg;
  localparam int BD_SIZE       = 32;
  localparam int BD_NUM_DEF    = BD_SIZE / 4;
  localparam int RAM_MEM_WIDTH = 32;
  // A descriptor is a system address word followed by a card block argument word.
  localparam int BD_WIDTH      = 2 * RAM_MEM_WIDTH;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ACK  = 1'b1
  } rd_state_e;
endpackage

// File: rtl/sd_bd_store_if.sv
// Host-write / master-read bus of one descriptor store direction.
interface sd_bd_store_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 4
);
  logic                  we_m;
  logic [DATA_WIDTH-1:0] dat_in_m;
  logic                  we_drop;
  logic                  bd_clr;
  logic                  re_s;
  logic                  ack_o_s;
  logic [DATA_WIDTH-1:0] dat_out_s;
  logic                  a_cmp;
  logic [CNT_W-1:0]      free_bd;

  modport master (
    output we_m, dat_in_m, bd_clr, re_s, a_cmp,
    input  we_drop, ack_o_s, dat_out_s, free_bd
  );

  modport slave (
    input  we_m, dat_in_m, bd_clr, re_s, a_cmp,
    output we_drop, ack_o_s, dat_out_s, free_bd
  );
endinterface

// File: rtl/sd_bd_ram.sv
// Simple dual-port descriptor RAM: synchronous write, registered read (1-cycle latency).
module sd_bd_ram #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  // Read register holds between reads so the master sees a stable word.
  always_ff @(posedge clk or posedge rst)
    if (rst)      rdata <= '0;
    else if (clr) rdata <= '0;
    else if (re)  rdata <= mem[raddr];
endmodule

// File: rtl/sd_bd_store.sv
// Buffer-descriptor store for one SD DMA direction: host writes word pairs, master reads them back.
module sd_bd_store
  import sd_bd_store_pkg::*;
#(
  parameter int BD_NUM     = BD_NUM_DEF,
  parameter int DATA_WIDTH = RAM_MEM_WIDTH,
  parameter int CNT_W      = $clog2(BD_NUM) + 1
) (
  input  logic          clk,
  input  logic          rst,
  sd_bd_store_if.slave  bus
);
  localparam int WA = $clog2(2 * BD_NUM);
  localparam int BA = $clog2(BD_NUM);

  logic [WA-1:0]         wr_ptr;
  logic [BA-1:0]         rd_bd;
  logic [1:0]            rd_idx;
  logic                  re_q;
  logic [CNT_W-1:0]      free_bd_q;
  logic                  we_drop_q;
  logic [DATA_WIDTH-1:0] rdata;
  rd_state_e             state, state_nxt;
  logic                  ack, rd_go;

  wire full    = (free_bd_q == '0);
  wire empty   = (free_bd_q == CNT_W'(BD_NUM));
  wire wr_ok   = bus.we_m & ~full & ~bus.bd_clr;
  // Only the second word of a pair makes a descriptor visible to the reader.
  wire commit  = wr_ok & wr_ptr[0];
  wire cmp_ok  = bus.a_cmp & ~empty & ~bus.bd_clr;
  wire rewind  = bus.re_s & ~re_q & (rd_idx == 2'd2) & ~bus.a_cmp;

  // Read FSM: state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= RD_IDLE;
    else     state <= state_nxt;

  // Read FSM: next state
  always_comb begin
    state_nxt = state;
    if (bus.bd_clr) state_nxt = RD_IDLE;
    else case (state)
      RD_IDLE: if (rd_go) state_nxt = RD_ACK;
      RD_ACK:  state_nxt = RD_IDLE;
      default: state_nxt = RD_IDLE;
    endcase
  end

  // Read FSM: outputs; a flush in the ack cycle swallows the ack.
  always_comb begin
    rd_go = (state == RD_IDLE) & bus.re_s & (rd_idx < 2'd2) & ~empty & ~bus.bd_clr;
    ack   = (state == RD_ACK) & ~bus.bd_clr;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr    <= '0;
      rd_bd     <= '0;
      rd_idx    <= '0;
      re_q      <= 1'b0;
      free_bd_q <= CNT_W'(BD_NUM);
      we_drop_q <= 1'b0;
    end else if (bus.bd_clr) begin
      wr_ptr    <= '0;
      rd_bd     <= '0;
      rd_idx    <= '0;
      re_q      <= 1'b0;
      free_bd_q <= CNT_W'(BD_NUM);
      we_drop_q <= 1'b0;
    end else begin
      re_q      <= bus.re_s;
      we_drop_q <= bus.we_m & full;
      if (wr_ok) wr_ptr <= wr_ptr + WA'(1);
      if (cmp_ok) rd_bd <= rd_bd + BA'(1);
      if (cmp_ok || rewind) rd_idx <= '0;
      else if (ack)         rd_idx <= rd_idx + 2'd1;
      if (commit && !cmp_ok)      free_bd_q <= free_bd_q - CNT_W'(1);
      else if (cmp_ok && !commit) free_bd_q <= free_bd_q + CNT_W'(1);
    end

  sd_bd_ram #(
    .DEPTH      (2 * BD_NUM),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.bd_clr),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (bus.dat_in_m),
    .re    (rd_go),
    .raddr ({rd_bd, rd_idx[0]}),
    .rdata (rdata)
  );

  assign bus.ack_o_s   = ack;
  assign bus.dat_out_s = rdata;
  assign bus.free_bd   = free_bd_q;
  assign bus.we_drop   = we_drop_q;
endmodule

// File: tb/tb_sd_bd_store.sv
// Directed bench for sd_bd_store with an ack-data scoreboard.
module tb_sd_bd_store;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t q[$];

  sd_bd_store_if #(.DATA_WIDTH(32), .CNT_W(4)) bus();

  sd_bd_store #(.BD_NUM(8), .DATA_WIDTH(32), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [31:0] d, input int c = -1);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    step(3);
    chk("drain", q.size(), 0);
  endtask

  task automatic wr(input logic [31:0] d);
    bus.we_m     = 1'b1;
    bus.dat_in_m = d;
    step();
    bus.we_m     = 1'b0;
  endtask

  task automatic cmp_pulse();
    bus.a_cmp = 1'b1;
    step();
    bus.a_cmp = 1'b0;
  endtask

  // Scoreboard side: every ack must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && bus.ack_o_s === 1'b1) begin
      if (q.size() == 0) chk("spurious_ack", bus.ack_o_s, 1'b0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("ack_data", bus.dat_out_s, e.data);
        if (e.cyc >= 0) chk("ack_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    int c;
    bus.we_m = 1'b0; bus.dat_in_m = '0; bus.bd_clr = 1'b0;
    bus.re_s = 1'b0; bus.a_cmp = 1'b0;
    step(2);
    chk("rst_free", bus.free_bd, 8);
    chk("rst_ack", bus.ack_o_s, 0);
    chk("rst_dat", bus.dat_out_s, 0);
    chk("rst_drop", bus.we_drop, 0);
    rst = 1'b0;

    // Empty store ignores read requests.
    bus.re_s = 1'b1;
    step(5);
    chk("idle_free", bus.free_bd, 8);

    // One descriptor, read with re_s held high.
    c = cyc;
    push(32'h1000_0000, c + 3);
    push(32'h0000_0200, c + 5);
    bus.we_m = 1'b1; bus.dat_in_m = 32'h1000_0000;
    step();
    chk("half_free", bus.free_bd, 8);
    bus.dat_in_m = 32'h0000_0200;
    step();
    bus.we_m = 1'b0;
    chk("commit_free", bus.free_bd, 7);
    drain();

    // Completion, then a stray completion on an empty store.
    cmp_pulse();
    chk("cmp_free", bus.free_bd, 8);
    cmp_pulse();
    chk("cmp_empty_free", bus.free_bd, 8);
    bus.re_s = 1'b0;
    step();

    // Fill all eight slots (wrapping), then overflow.
    for (int i = 0; i < 8; i++) begin
      wr(32'hA000_0000 + i);
      wr(32'hB000_0000 + i);
    end
    chk("full_free", bus.free_bd, 0);
    wr(32'h0000_DEAD);
    chk("drop_pulse", bus.we_drop, 1);
    chk("drop_free", bus.free_bd, 0);
    step();
    chk("drop_once", bus.we_drop, 0);
    cmp_pulse();
    chk("refill_free1", bus.free_bd, 1);
    wr(32'hC000_0000);
    wr(32'hC000_0001);
    chk("refill_free0", bus.free_bd, 0);
    repeat (6) cmp_pulse();
    chk("six_cmp_free", bus.free_bd, 6);

    // Head is now the descriptor that wrapped into slot 0.
    push(32'hA000_0007);
    push(32'hB000_0007);
    bus.re_s = 1'b1;
    drain();
    bus.re_s = 1'b0;
    step();

    // Rewind: a new re_s edge after both words re-reads the same head.
    push(32'hA000_0007);
    push(32'hB000_0007);
    bus.re_s = 1'b1;
    drain();
    bus.re_s = 1'b0;
    step();

    // Commit and completion in the same cycle leave free_bd unchanged.
    wr(32'hD000_0000);
    bus.a_cmp = 1'b1;
    wr(32'hD000_0001);
    bus.a_cmp = 1'b0;
    chk("same_cycle_free", bus.free_bd, 6);
    wr(32'hE000_0000);
    wr(32'hE000_0001);
    chk("three_held_free", bus.free_bd, 5);

    // Flush in the cycle a read would launch: no ack, back to reset state.
    bus.re_s = 1'b1; bus.bd_clr = 1'b1;
    step();
    bus.bd_clr = 1'b0;
    chk("clr_free", bus.free_bd, 8);
    chk("clr_dat", bus.dat_out_s, 0);
    step(3);
    bus.re_s = 1'b0;
    step();
    chk("clr_no_ack", q.size(), 0);

    // Next pair lands in slot 0.
    push(32'h5555_0000);
    push(32'h6666_0000);
    wr(32'h5555_0000);
    wr(32'h6666_0000);
    chk("post_clr_free", bus.free_bd, 7);
    bus.re_s = 1'b1;
    drain();
    bus.re_s = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
